tick_count_controller: RTL and testbench

//   Sequences a multi-digit BCD event counter driven by the periodic single-cycle enable from the

---
 rtl/tick_count_controller_if.sv | 42 ++++
 rtl/tick_count_controller.sv | 149 ++++++++++++++
 tb/tb_tick_count_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_count_controller_if.sv
// Bundle between the tick/button sources and the BCD event counter.
// Ports: tick, start_n, stop_n (and down when DOWN_COUNT_EN) in;
//        bcd, running, wrap out.
// Modports: master drives the inputs, slave is the counter itself.

interface tick_count_controller_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic                  start_n;
    logic                  stop_n;
`ifdef DOWN_COUNT_EN
    logic                  down;
`endif
    logic [4*DIGITS-1:0]   bcd;
    logic                  running;
    logic                  wrap;

    modport master (
`ifdef DOWN_COUNT_EN
        output down,
`endif
        output tick,
        output start_n,
        output stop_n,
        input  bcd,
        input  running,
        input  wrap
    );

    modport slave (
`ifdef DOWN_COUNT_EN
        input  down,
`endif
        input  tick,
        input  start_n,
        input  stop_n,
        output bcd,
        output running,
        output wrap
    );
endinterface

// File: rtl/tick_count_controller.sv
// Run/pause/idle sequencer for a DIGITS-wide BCD event counter stepped by
// a prescaled tick; start/stop buttons are active-low and already debounced.
// Ports: clock, reset (async, active-low), bus (tick_count_controller_if.slave):
//   tick, start_n, stop_n in; bcd, running, wrap out.
// Build option: DOWN_COUNT_EN adds bus.down to select decrementing.

module tick_count_controller #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    tick_count_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(TICK_DIV - 1);

    state_t              state;
    state_t              state_next;
    logic                start_q;
    logic                stop_q;
    logic                start_press;
    logic                stop_press;
    logic [7:0]          pre;
    logic [4*DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0] bcd_next;
    logic [3:0]          digit;
    logic                carry;
    logic                count_en;
    logic                step;
    logic                clear;
    logic                running_q;
    logic                wrap_q;
    logic                down_sel;

`ifdef DOWN_COUNT_EN
    assign down_sel = bus.down;
`else
    assign down_sel = 1'b0;
`endif

    // Falling edge of a released-high button is one press.
    assign start_press = start_q & ~bus.start_n;
    assign stop_press  = stop_q & ~bus.stop_n;

    // A stop press in the same cycle suppresses the tick.
    assign count_en = (state == RUN) & bus.tick & ~stop_press;
    assign step     = count_en & (pre == PRE_LAST);
    assign clear    = (state == PAUSE) & stop_press;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_press && !stop_press) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop_press) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_press) begin
                    state_next = IDLE;
                end else if (start_press) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ripple carry/borrow across digits; carry left over means all digits
    // rolled, i.e. the counter wrapped.
    always_comb begin
        bcd_next = bcd;
        digit    = 4'd0;
        carry    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            digit = bcd[4*k +: 4];
            if (carry) begin
                if (down_sel) begin
                    if (digit == 4'd0) begin
                        digit = 4'd9;
                    end else begin
                        digit = digit - 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd9) begin
                        digit = 4'd0;
                    end else begin
                        digit = digit + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            bcd_next[4*k +: 4] = digit;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            pre       <= 8'd0;
            bcd       <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            start_q   <= bus.start_n;
            stop_q    <= bus.stop_n;
            running_q <= (state_next == RUN);
            wrap_q    <= step & carry;
            if (clear) begin
                pre <= 8'd0;
                bcd <= '0;
            end else if (count_en) begin
                if (pre == PRE_LAST) begin
                    pre <= 8'd0;
                    bcd <= bcd_next;
                end else begin
                    pre <= pre + 8'd1;
                end
            end
        end
    end

    assign bus.bcd     = bcd;
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_tick_count_controller.sv
// Bench for tick_count_controller: two instances (TICK_DIV 1 and 3)
// share stimulus and are checked each cycle against an integer model.

module tb_tick_count_controller;
    localparam int DIGITS  = 4;
    localparam int MAXC    = 9999;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic clock = 1'b0;
    logic reset;
    logic tick;
    logic start_n;
    logic stop_n;
`ifdef DOWN_COUNT_EN
    logic down;
`endif

    always #5 clock = ~clock;

    tick_count_controller_if #(.DIGITS(DIGITS)) bus1 ();
    tick_count_controller_if #(.DIGITS(DIGITS)) bus3 ();

    assign bus1.tick    = tick;
    assign bus1.start_n = start_n;
    assign bus1.stop_n  = stop_n;
    assign bus3.tick    = tick;
    assign bus3.start_n = start_n;
    assign bus3.stop_n  = stop_n;
`ifdef DOWN_COUNT_EN
    assign bus1.down = down;
    assign bus3.down = down;
`endif

    tick_count_controller #(.DIGITS(DIGITS), .TICK_DIV(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    tick_count_controller #(.DIGITS(DIGITS), .TICK_DIV(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.slave)
    );

    int divs[2] = '{1, 3};
    int m_state[2];
    int m_count[2];
    int m_pre[2];
    bit m_wrap[2];
    bit prev_start;
    bit prev_stop;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = S_IDLE;
            m_count[i] = 0;
            m_pre[i]   = 0;
            m_wrap[i]  = 1'b0;
        end
        prev_start = 1'b1;
        prev_stop  = 1'b1;
    endtask

    // Advances the model by one clock using the inputs as sampled at the edge.
    task automatic model_step();
        bit sp;
        bit tp;
        bit dn;
        if (reset == 1'b0) begin
            model_reset();
            return;
        end
        sp = prev_start && (start_n == 1'b0);
        tp = prev_stop && (stop_n == 1'b0);
        dn = 1'b0;
`ifdef DOWN_COUNT_EN
        dn = (down == 1'b1);
`endif
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 1'b0;
            if (m_state[i] == S_RUN && tick == 1'b1 && !tp) begin
                m_pre[i] = m_pre[i] + 1;
                if (m_pre[i] == divs[i]) begin
                    m_pre[i] = 0;
                    if (dn) begin
                        if (m_count[i] == 0) begin
                            m_count[i] = MAXC;
                            m_wrap[i]  = 1'b1;
                        end else begin
                            m_count[i] = m_count[i] - 1;
                        end
                    end else begin
                        m_count[i] = m_count[i] + 1;
                        if (m_count[i] > MAXC) begin
                            m_count[i] = 0;
                            m_wrap[i]  = 1'b1;
                        end
                    end
                end
            end
            if (tp) begin
                if (m_state[i] == S_RUN) begin
                    m_state[i] = S_PAUSE;
                end else if (m_state[i] == S_PAUSE) begin
                    m_state[i] = S_IDLE;
                    m_count[i] = 0;
                    m_pre[i]   = 0;
                end
            end else if (sp && m_state[i] != S_RUN) begin
                m_state[i] = S_RUN;
            end
        end
        prev_start = start_n;
        prev_stop  = stop_n;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bcd1", 32'(bus1.bcd), 32'(to_bcd(m_count[0])));
        chk("run1", 32'(bus1.running), 32'(m_state[0] == S_RUN));
        chk("wrap1", 32'(bus1.wrap), 32'(m_wrap[0]));
        chk("bcd3", 32'(bus3.bcd), 32'(to_bcd(m_count[1])));
        chk("run3", 32'(bus3.running), 32'(m_state[1] == S_RUN));
        chk("wrap3", 32'(bus3.wrap), 32'(m_wrap[1]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic quiet(input int n);
        tick = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            quiet(int'($urandom_range(9, 1)));
            tick = 1'b1;
            cycle();
            tick = 1'b0;
        end
    endtask

    task automatic press_start(input bit with_tick);
        start_n = 1'b0;
        tick    = with_tick;
        cycle();
        start_n = 1'b1;
        tick    = 1'b0;
        cycle();
    endtask

    task automatic press_stop(input bit with_tick);
        stop_n = 1'b0;
        tick   = with_tick;
        cycle();
        stop_n = 1'b1;
        tick   = 1'b0;
        cycle();
    endtask

    task automatic run_to(input int target);
        int b;
        b = 0;
        tick = 1'b1;
        while (m_count[0] != target && b < 20000) begin
            cycle();
            b++;
        end
        tick = 1'b0;
        chk("run_to", 32'(bus1.bcd), 32'(to_bcd(target)));
    endtask

    initial begin
        reset   = 1'b0;
        tick    = 1'b0;
        start_n = 1'b1;
        stop_n  = 1'b1;
`ifdef DOWN_COUNT_EN
        down    = 1'b0;
`endif
        #2;
        model_reset();
        check_all();
        chk("rst_bcd", 32'(bus1.bcd), 32'h0);
        quiet(2);
        @(negedge clock);
        reset = 1'b1;
        quiet(2);

        // start press with a coincident tick, then 12 ticks
        press_start(1'b1);
        ticks(12);
        chk("t1_bcd1", 32'(bus1.bcd), 32'h0012);
        chk("t1_bcd3", 32'(bus3.bcd), 32'h0004);
        chk("t1_run", 32'(bus1.running), 32'h1);

        // pause holds, resume continues, stop twice clears
        ticks(30);
        chk("t2_42", 32'(bus1.bcd), 32'h0042);
        press_stop(1'b1);
        ticks(5);
        chk("t2_hold", 32'(bus1.bcd), 32'h0042);
        chk("t2_pause", 32'(bus1.running), 32'h0);
        press_start(1'b0);
        ticks(3);
        chk("t2_45", 32'(bus1.bcd), 32'h0045);
        press_stop(1'b0);
        press_stop(1'b0);
        chk("t2_clr", 32'(bus1.bcd), 32'h0);

        // wrap from all nines; simultaneous start+stop
        press_start(1'b0);
        run_to(9998);
        tick = 1'b1;
        cycle();
        chk("t3_9999", 32'(bus1.bcd), 32'h9999);
        cycle();
        chk("t3_zero", 32'(bus1.bcd), 32'h0);
        chk("t3_wrap", 32'(bus1.wrap), 32'h1);
        tick = 1'b0;
        cycle();
        chk("t3_wrap0", 32'(bus1.wrap), 32'h0);
        start_n = 1'b0;
        stop_n  = 1'b0;
        cycle();
        start_n = 1'b1;
        stop_n  = 1'b1;
        cycle();
        chk("t3_both", 32'(bus1.running), 32'h0);
        press_stop(1'b0);

        // prescale by 3; held start counts once
        press_start(1'b0);
        ticks(9);
        chk("t4_div3", 32'(bus3.bcd), 32'h0003);
        press_stop(1'b0);
        start_n = 1'b0;
        for (int c = 0; c < 50; c++) begin
            stop_n = (c != 20);
            tick   = ($urandom_range(3, 0) == 0);
            cycle();
        end
        stop_n  = 1'b1;
        start_n = 1'b1;
        tick    = 1'b0;
        cycle();
        chk("t4_held", 32'(bus3.running), 32'h0);
        press_stop(1'b0);

        // asynchronous reset mid-run
        press_start(1'b0);
        run_to(317);
        tick = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t5_bcd", 32'(bus1.bcd), 32'h0);
        chk("t5_run", 32'(bus1.running), 32'h0);
        tick = 1'b0;
        quiet(3);
        @(negedge clock);
        reset = 1'b1;
        quiet(3);
        chk("t5_idle", 32'(bus1.running), 32'h0);
        press_start(1'b0);
        ticks(2);
        chk("t5_resume", 32'(bus1.bcd), 32'h0002);

`ifdef DOWN_COUNT_EN
        press_stop(1'b0);
        press_stop(1'b0);
        press_start(1'b0);
        ticks(1);
        down = 1'b1;
        tick = 1'b1;
        cycle();
        chk("t6_zero", 32'(bus1.bcd), 32'h0);
        cycle();
        chk("t6_9999", 32'(bus1.bcd), 32'h9999);
        chk("t6_wrap", 32'(bus1.wrap), 32'h1);
        tick = 1'b0;
        down = 1'b0;
        press_stop(1'b0);
        press_stop(1'b0);
        press_start(1'b0);
        run_to(100);
        down = 1'b1;
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        chk("t6_99", 32'(bus1.bcd), 32'h0099);
        down = 1'b0;
`endif

        // random buttons and ticks
        repeat (1500) begin
            tick    = ($urandom_range(3, 0) == 0);
            start_n = ($urandom_range(7, 0) != 0);
            stop_n  = ($urandom_range(11, 0) != 0);
`ifdef DOWN_COUNT_EN
            down    = ($urandom_range(1, 0) == 0);
`endif
            cycle();
        end
        tick    = 1'b0;
        start_n = 1'b1;
        stop_n  = 1'b1;
        quiet(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
